// File: rtl/assoc_cache.sv
// assoc_cache: fully-associative cache between the core load/store path and the memory bus.
// Reads that miss allocate an entry; writes go through to memory and never allocate.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_*                core request (valid/ready); resp_* one-cycle response pulse, no backpressure
//   inv                  invalidate all entries (honoured only in IDLE)
//   mem_*                blocking request/acknowledge toward backing memory
// Build option: define CACHE_LRU_EN for true-LRU replacement; the default is round-robin.
module assoc_cache #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CELL_CNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  inv,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int IW = $clog2(CELL_CNT);

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR} state_t;
  state_t state, state_nxt;

  logic [CELL_CNT-1:0]   valid;
  logic [ADDR_WIDTH-1:0] tag  [CELL_CNT];
  logic [DATA_WIDTH-1:0] data [CELL_CNT];

  logic          accept, hit, has_inv, fill, wr_hit;
  logic [IW-1:0] hit_idx, inv_idx, policy_idx, victim;

  assign req_ready = (state == IDLE) && !inv;
  assign accept    = req_valid && req_ready;
  // Memory request is a pure function of state so an async reset drops it immediately.
  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == MEM_WR);
  assign fill      = (state == MEM_RD) && mem_ack;

  // Tags are unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < CELL_CNT; i++) begin
      if (valid[i] && tag[i] == req_addr) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Lowest-index invalid entry wins: scan from the top so the last assignment is the lowest.
  always_comb begin
    has_inv = 1'b0;
    inv_idx = '0;
    for (int i = CELL_CNT - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_inv = 1'b1;
        inv_idx = IW'(i);
      end
    end
  end

`ifdef CACHE_LRU_EN
  // Ages form a permutation of 0..CELL_CNT-1; the oldest entry (CELL_CNT-1) is the victim.
  logic [IW-1:0] age [CELL_CNT];
  logic          touch_en;
  logic [IW-1:0] touch_idx;

  assign touch_en  = (accept && hit) || fill;
  assign touch_idx = fill ? victim : hit_idx;

  always_comb begin
    policy_idx = '0;
    for (int i = 0; i < CELL_CNT; i++)
      if (age[i] == IW'(CELL_CNT - 1)) policy_idx = IW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELL_CNT; i++) age[i] <= IW'(i);
    end else if (touch_en) begin
      for (int i = 0; i < CELL_CNT; i++) begin
        if (IW'(i) == touch_idx)         age[i] <= '0;
        else if (age[i] < age[touch_idx]) age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  // Round-robin pointer only advances when a fill actually evicts a valid entry.
  logic [IW-1:0] rr_ptr;
  assign policy_idx = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rr_ptr <= '0;
    else if (fill && !has_inv) rr_ptr <= rr_ptr + 1'b1;
  end
`endif

  assign victim = has_inv ? inv_idx : policy_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_we)   state_nxt = MEM_WR;
          else if (!hit) state_nxt = MEM_RD;
        end
      end
      MEM_RD, MEM_WR: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_hit     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && inv) begin
        valid <= '0;
      end else if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        wr_hit    <= hit;
        if (!req_we && hit) begin
          resp_valid <= 1'b1;
          resp_rdata <= data[hit_idx];
          resp_hit   <= 1'b1;
        end
      end else if (state != IDLE && mem_ack) begin
        resp_valid <= 1'b1;
        if (state == MEM_RD) begin
          valid[victim] <= 1'b1;
          resp_rdata    <= mem_rdata;
          resp_hit      <= 1'b0;
        end else begin
          resp_hit <= wr_hit;
        end
      end
    end
  end

  // Entry payload carries no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (accept && req_we && hit) begin
      data[hit_idx] <= req_wdata;
    end else if (fill) begin
      tag[victim]  <= mem_addr;
      data[victim] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we, inv;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_hit;
  logic [7:0] resp_rdata;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int ntests = 0;
  int nfail  = 0;

  assoc_cache #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CELL_CNT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inv(inv),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: backing memory, a table of cache entries, a recency list
  // (front = most recently used) and a round-robin counter.
  logic [7:0] mem_m [256];
  bit         m_valid [4];
  logic [7:0] m_tag [4];
  logic [7:0] m_data [4];
  int         order[$];
  int         rr;
  logic [7:0] last_rdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    order.delete();
    for (int i = 0; i < 4; i++) order.push_back(i);
    rr = 0;
    last_rdata = 8'h00;
  endfunction

  function automatic int m_lookup(input logic [7:0] a);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic void m_touch(input int k);
    for (int i = 0; i < order.size(); i++)
      if (order[i] == k) begin order.delete(i); break; end
    order.push_front(k);
  endfunction

  function automatic void m_fill(input logic [7:0] a, input logic [7:0] d);
    int k = -1;
    for (int i = 3; i >= 0; i--) if (!m_valid[i]) k = i;
    if (k < 0) begin
`ifdef CACHE_LRU_EN
      k = order[order.size() - 1];
`else
      k = rr;
      rr = (rr + 1) % 4;
`endif
    end
    m_valid[k] = 1'b1; m_tag[k] = a; m_data[k] = d;
    m_touch(k);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic access(input bit we, input logic [7:0] a, input logic [7:0] d,
                        input int waitc, output bit obs_hit);
    int k = m_lookup(a);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1 check("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (!we && k >= 0) begin
      check("rdhit_valid", resp_valid, 1);
      check("rdhit_hit", resp_hit, 1);
      check("rdhit_data", resp_rdata, m_data[k]);
      check("rdhit_nomem", mem_req, 0);
      obs_hit = resp_hit;
      last_rdata = m_data[k];
      m_touch(k);
    end else begin
      check("mem_req_rise", mem_req, 1);
      check("mem_we", mem_we, we);
      check("mem_addr", mem_addr, a);
      if (we) check("mem_wdata", mem_wdata, d);
      for (int c = 0; c <= waitc; c++) begin
        if (c > 0) check("mem_req_held", mem_req, 1);
        check("no_early_resp", resp_valid, 0);
        mem_rdata = 8'($urandom);
        if (c == waitc) begin
          mem_ack = 1'b1;
          if (!we) mem_rdata = mem_m[a];
        end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check("resp_valid", resp_valid, 1);
      check("mem_req_drop", mem_req, 0);
      obs_hit = resp_hit;
      if (we) begin
        check("wr_hit", resp_hit, (k >= 0));
        check("wr_rdata_hold", resp_rdata, last_rdata);
        mem_m[a] = d;
        if (k >= 0) begin m_data[k] = d; m_touch(k); end
      end else begin
        check("rdmiss_hit", resp_hit, 0);
        check("rdmiss_data", resp_rdata, mem_m[a]);
        last_rdata = mem_m[a];
        m_fill(a, mem_m[a]);
      end
    end
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
  endtask

  task automatic pulse_inv(input bit with_req, input logic [7:0] a);
    inv = 1'b1; req_valid = with_req; req_we = 1'b0; req_addr = a;
    #1 check("inv_ready", req_ready, 0);
    @(negedge clk);
    inv = 1'b0; req_valid = 1'b0;
    check("inv_noresp", resp_valid, 0);
    check("inv_nomem", mem_req, 0);
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    logic [7:0] b2b [3];
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; inv = 0;
    mem_ack = 0; mem_rdata = 0; rst = 1'b1;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
    mem_m[8'h10] = 8'hA5;
    m_reset();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_hit", resp_hit, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Miss with 3 wait cycles, then hit; write-through behaviour
    access(0, 8'h10, 8'h00, 3, h);
    check("first_rd_data", resp_rdata, 8'hA5);
    access(0, 8'h10, 8'h00, 0, h);
    check("reread_hit", h, 1);
    access(1, 8'h10, 8'h3C, 1, h);
    check("wr_hit_flag", h, 1);
    access(0, 8'h10, 8'h00, 0, h);
    check("rd_after_wr", resp_rdata, 8'h3C);
    access(1, 8'h20, 8'h55, 2, h);
    check("wr_miss_flag", h, 0);
    access(0, 8'h20, 8'h00, 0, h);
    check("no_allocate_on_wr", h, 0);

    // Replacement policy
    apply_reset();
    for (int i = 1; i <= 4; i++) access(0, 8'(i), 8'h00, i % 3, h);
    access(0, 8'h01, 8'h00, 0, h);
    access(0, 8'h05, 8'h00, 1, h);
    access(0, 8'h01, 8'h00, 0, h);
`ifdef CACHE_LRU_EN
    check("evict_policy", h, 1);
`else
    check("evict_policy", h, 0);
`endif

    // Back-to-back read hits
    b2b[0] = 8'h03; b2b[1] = 8'h04; b2b[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      int k = m_lookup(b2b[i]);
      req_valid = 1'b1; req_we = 1'b0; req_addr = b2b[i];
      #1 check("b2b_ready", req_ready, 1);
      @(negedge clk);
      check("b2b_valid", resp_valid, 1);
      check("b2b_hit", resp_hit, 1);
      if (k >= 0) begin
        check("b2b_data", resp_rdata, m_data[k]);
        last_rdata = m_data[k];
        m_touch(k);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", resp_valid, 0);

    // Invalidate with a request present
    pulse_inv(1, 8'h03);
    access(0, 8'h03, 8'h00, 0, h);
    check("inv_miss_03", h, 0);
    access(0, 8'h04, 8'h00, 1, h);
    access(0, 8'h01, 8'h00, 0, h);

    // Reset in the middle of a memory transaction
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_mem_req_up", mem_req, 1);
    rst = 1'b1;
    #1 check("abort_mem_req_drop", mem_req, 0);
    check("abort_noresp", resp_valid, 0);
    @(negedge clk);
    check("abort_noresp2", resp_valid, 0);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    access(0, 8'h03, 8'h00, 0, h);
    check("post_abort_miss", h, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulse_inv(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
      end else begin
        access(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 7)),
               8'($urandom), $urandom_range(0, 3), h);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised fully-associative cache with valid bits, a request/response handshake toward the core and a blocking request/acknowledge handshake toward backing memory. Read misses allocate; writes are write-through, no-allocate. It sits between the bf8b core's load/store path and the memory bus, and replaces the fixed-size shift-register cell store.

## Interface
- ADDR_WIDTH, 8: address / tag width in bits.
- DATA_WIDTH, 8: data word width in bits.
- CELL_CNT, 4: number of entries; power of two, at least 2. IW = clog2(CELL_CNT).

- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  request accepted on a rising edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- inv  in  1  invalidate all entries.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  DATA_WIDTH  read data; holds its value until the next response.
- resp_hit  out  1  1 when the access hit in the cache.
- mem_req  out  1  memory access request; held high until acknowledged.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.

## Operation
- Each entry holds {valid, tag[ADDR_WIDTH], data[DATA_WIDTH]}. A hit means valid && tag == address. Tags are unique by construction, so at most one entry matches.
- States: IDLE, MEM_RD, MEM_WR.
- req_ready = (state == IDLE) && !inv.
- In IDLE with inv = 1: all valid bits clear at the edge. Any request that cycle is not accepted. inv is ignored outside IDLE.
- The tag compare is combinational on req_addr during IDLE.
- Read hit: at the accept edge, resp_valid = 1, resp_rdata = entry data and resp_hit = 1. The state stays IDLE, so back-to-back accepts are possible. The replacement state updates (LRU only).
- Read miss: go to MEM_RD with mem_req = 1, mem_we = 0, mem_addr = captured address. On mem_ack:
  - mem_rdata is written into the victim entry, which is set valid.
  - resp_valid = 1, resp_rdata = mem_rdata, resp_hit = 0.
  - mem_req drops and the state returns to IDLE.
- Write: go to MEM_WR with mem_req = 1, mem_we = 1, and mem_addr / mem_wdata taken from the captured request.
  - On a hit, entry data is updated at the accept edge.
  - On a miss, no entry changes.
  - On mem_ack: resp_valid = 1, resp_hit = hit status at accept, resp_rdata unchanged. The state returns to IDLE.
- Victim selection: lowest-index invalid entry if any exists, otherwise the replacement policy (see Configuration).
- mem_addr, mem_wdata and mem_we are stable while mem_req = 1. mem_ack while mem_req = 0 is ignored.

## Timing
- Reset values:
  - state IDLE; all valid = 0.
  - req_ready = 1 (when inv = 0); resp_valid = 0; resp_rdata = 0; resp_hit = 0.
  - mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - Round-robin pointer = 0; LRU age[i] = i.
- Read hit latency: resp_valid is high in the cycle after the accept edge. One request per cycle.
- Miss / write latency: mem_req rises in the cycle after accept. resp_valid is high in the cycle after the edge that samples mem_ack. Total = 2 + memory wait cycles.
- mem_ack in the first mem_req cycle is legal.
- Reset mid-transaction aborts asynchronously: mem_req drops immediately and no response is issued.

## Configuration
- CACHE_LRU_EN defined: true LRU replacement.
  - Each entry has an IW-bit age; ages always form a permutation of 0..CELL_CNT-1.
  - On a hit or fill of entry k: age[k] becomes 0, and every entry with age < old age[k] increments.
  - The victim, when all entries are valid, is the entry with age CELL_CNT-1.
  - Write hits update ages; write misses do not.
- CACHE_LRU_EN undefined: round-robin replacement.
  - The IW-bit pointer selects the victim when all entries are valid.
  - The pointer increments mod CELL_CNT after each such fill.
  - Hits do not affect replacement.

## Test plan
- Reset, read 0x10 (mem returns 0xA5 after 3 wait cycles) → mem_req 4 cycles, resp_hit = 0, rdata 0xA5. Re-read 0x10 → resp_valid next cycle, resp_hit = 1, rdata 0xA5, no mem_req.
- Write 0x10 = 0x3C after the fill → mem write of 0x3C at 0x10, resp_hit = 1. Read 0x10 → hit, 0x3C. Write 0x20 (miss) → mem write, resp_hit = 0; a following read of 0x20 misses.
- Fill 0x01..0x04, then read 0x05 → round-robin evicts 0x01; LRU build, after re-reading 0x01, evicts 0x02. Then read 0x01 → round-robin misses; LRU hits.
- Fill 4 entries, pulse inv in IDLE with req_valid = 1 → req_ready = 0 that cycle. The next read of each address misses.
- Assert rst while mem_req = 1 → mem_req = 0 immediately, no resp_valid. After release, a read of a previously filled address misses.
- Back-to-back read hits on 3 consecutive cycles → resp_valid high 3 consecutive cycles with the correct data each cycle.
